// File: rtl/seq_scan_ctrl.sv
// Serial scan controller for a 1010 Moore detector: shifts a word out MSB-first,
// counts cycles with det_z high and reports the count and first-match bit index.
module seq_scan_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             det_x,
    output logic             det_reset,
    input  logic             det_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_count,
    output logic             res_hit,
    output logic [IW-1:0]    res_first
);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] K_LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    k_reg, k_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             hit_reg, hit_next;
    logic [IW-1:0]    first_reg, first_next;
    logic             det_reset_reg, det_reset_next;

    logic [WIDTH-1:0] shreg_shl;
    logic [CW-1:0]    k_prev;
    logic             take_sample;

    assign shreg_shl[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shl
            assign shreg_shl[gi] = shreg_reg[gi-1];
        end
    endgenerate

    // det_z lags det_x by one detector edge, so the sample taken at the end of a
    // cycle belongs to the bit sent one cycle earlier (index k-1).
    assign k_prev      = k_reg - CW'(1);
    assign take_sample = det_z && !abort &&
                         ((state_reg == SHIFT && k_reg != '0) || state_reg == DRAIN);

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        k_next     = k_reg;
        count_next = count_reg;
        hit_next   = hit_reg;
        first_next = first_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    shreg_next = in_data;
                    k_next     = '0;
                    count_next = '0;
                    hit_next   = 1'b0;
                    first_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    shreg_next = shreg_shl;
                    k_next     = k_reg + CW'(1);
                    if (k_reg == K_LAST)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = abort ? IDLE : DONE;
            end
            DONE: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (take_sample) begin
            count_next = count_reg + CW'(1);
            if (!hit_reg) begin
                hit_next   = 1'b1;
                first_next = k_prev[IW-1:0];
            end
        end

        det_reset_next = (state_next == IDLE) || (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            k_reg         <= '0;
            count_reg     <= '0;
            hit_reg       <= 1'b0;
            first_reg     <= '0;
            det_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            k_reg         <= k_next;
            count_reg     <= count_next;
            hit_reg       <= hit_next;
            first_reg     <= first_next;
            det_reset_reg <= det_reset_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign res_valid = (state_reg == DONE);
    assign det_x     = (state_reg == SHIFT) && shreg_reg[WIDTH-1];
    assign det_reset = det_reset_reg;
    assign res_count = count_reg;
    assign res_hit   = hit_reg;
    assign res_first = first_reg;

endmodule
